ai_paddle_ctrl: RTL and testbench

Sequencer for the computer-controlled paddle. Owns an internal move-rate prescaler, so the paddle runs on the system clock with a one-cycle step enable rather than on a derived clock. On each step it moves the paddle one pixel toward the ball, or back toward centre when the ball is receding. Sits between the ball-motion logic (ball position and direction) and the renderer and collision logic (paddle position).

---
 rtl/pong_pkg.sv | 19 +
 rtl/pong_tick_gen.sv | 38 +++
 rtl/ai_paddle_ctrl.sv | 142 ++++++++++++++
 tb/tb_ai_paddle_ctrl.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pong_pkg.sv
// Shared playfield geometry and the AI paddle state encoding.
package pong_pkg;

  localparam int unsigned SCREEN_H = 480;
  localparam int unsigned PADDLE_H = 80;
  localparam int unsigned Y_W      = 10;

  // Highest legal paddle top edge, and the rest position between rallies.
  localparam logic [Y_W-1:0] Y_MAX  = Y_W'(SCREEN_H - PADDLE_H);
  localparam logic [Y_W-1:0] CENTER = Y_W'((SCREEN_H - PADDLE_H) / 2);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT     = 2'd1,
    TRACK    = 2'd2,
    RECENTER = 2'd3
  } ai_state_t;

endpackage

// File: rtl/pong_tick_gen.sv
// Enable-gated prescaler: one-cycle step pulse every DIV cycles, held at 0 while idle.
module pong_tick_gen #(
  parameter int unsigned DIV = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  input  logic clr_i,
  output logic step_o
);

  localparam int unsigned CW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign step_o = en_i && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i || !en_i) begin
      cnt_d = '0;
    end else if (cnt_q == LAST) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/ai_paddle_ctrl.sv
// Computer paddle sequencer: steps one pixel toward the ball or back to centre.
// Build option AI_REACT_DELAY_EN adds a WAIT phase of REACT_STEPS steps before tracking.
module ai_paddle_ctrl
  import pong_pkg::*;
#(
  parameter int unsigned TICK_DIV = 227273,
  parameter int unsigned DEADBAND = 4
`ifdef AI_REACT_DELAY_EN
  , parameter int unsigned REACT_STEPS = 8
`endif
) (
  input  logic           clock_in,
  input  logic           reset,
  input  logic           enable,
  input  logic           serve,
  input  logic [Y_W-1:0] ball_y,
  input  logic           ball_toward,
  output logic [Y_W-1:0] paddle_y,
  output logic           moving,
  output logic [1:0]     ai_state
);

  localparam logic signed [Y_W:0] DB_P = (Y_W+1)'(DEADBAND);
  localparam logic signed [Y_W:0] DB_N = -DB_P;

`ifdef AI_REACT_DELAY_EN
  localparam ai_state_t ENTRY = WAIT;
  localparam int unsigned RW = $clog2(REACT_STEPS + 1);
  logic [RW-1:0] react_q, react_d;
`else
  localparam ai_state_t ENTRY = TRACK;
`endif

  ai_state_t       state_q, state_d;
  logic [Y_W-1:0]  y_q, y_d;
  logic            mov_q, mov_d;
  logic            step;
  logic            inc, dec;
  logic signed [Y_W:0] err;

  pong_tick_gen #(.DIV(TICK_DIV)) u_tick (
    .clk_i  (clock_in),
    .rst_i  (reset),
    .en_i   (enable),
    .clr_i  (serve),
    .step_o (step)
  );

  assign err = $signed({1'b0, ball_y}) - $signed({1'b0, y_q} + (Y_W+1)'(PADDLE_H / 2));

  always_comb begin
    state_d = state_q;
    y_d     = y_q;
    mov_d   = 1'b0;
    inc     = 1'b0;
    dec     = 1'b0;
`ifdef AI_REACT_DELAY_EN
    react_d = react_q;
`endif
    if (serve) begin
      y_d     = CENTER;
      state_d = ball_toward ? ENTRY : RECENTER;
`ifdef AI_REACT_DELAY_EN
      react_d = '0;
`endif
    end else if (!enable) begin
      state_d = IDLE;
`ifdef AI_REACT_DELAY_EN
      react_d = '0;
`endif
    end else begin
      // A direction change this cycle wins over any motion the step would cause.
      unique case (state_q)
        IDLE: state_d = ball_toward ? ENTRY : RECENTER;
`ifdef AI_REACT_DELAY_EN
        WAIT: begin
          if (!ball_toward) begin
            state_d = RECENTER;
            react_d = '0;
          end else if (step) begin
            if (react_q == RW'(REACT_STEPS - 1)) begin
              react_d = '0;
              state_d = TRACK;
            end else begin
              react_d = react_q + RW'(1);
            end
          end
        end
`endif
        TRACK: begin
          if (!ball_toward) begin
            state_d = RECENTER;
          end else if (step) begin
            inc = (err > DB_P);
            dec = (err < DB_N);
          end
        end
        RECENTER: begin
          if (ball_toward) begin
            state_d = ENTRY;
          end else if (step) begin
            inc = (y_q < CENTER);
            dec = (y_q > CENTER);
          end
        end
        default: state_d = IDLE;
      endcase
      // Out-of-range steps are dropped, so moving stays low at the limits.
      if (inc && (y_q < Y_MAX)) begin
        y_d   = y_q + Y_W'(1);
        mov_d = 1'b1;
      end
      if (dec && (y_q != '0)) begin
        y_d   = y_q - Y_W'(1);
        mov_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clock_in) begin
    if (reset) begin
      state_q <= IDLE;
      y_q     <= CENTER;
      mov_q   <= 1'b0;
`ifdef AI_REACT_DELAY_EN
      react_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      y_q     <= y_d;
      mov_q   <= mov_d;
`ifdef AI_REACT_DELAY_EN
      react_q <= react_d;
`endif
    end
  end

  assign paddle_y = y_q;
  assign moving   = mov_q;
  assign ai_state = state_q;

endmodule

// File: tb/tb_ai_paddle_ctrl.sv
// Self-checking bench for ai_paddle_ctrl against an integer behavioural model.
module tb_ai_paddle_ctrl;

  localparam int TD   = 4;
  localparam int CEN  = 200;
  localparam int YMAX = 400;
  localparam int HALF = 40;
  localparam int DB   = 4;
`ifdef AI_REACT_DELAY_EN
  localparam int RS    = 8;
  localparam int ENTRY = 1;
`else
  localparam int ENTRY = 2;
`endif

  logic       clock_in = 1'b0;
  logic       reset, enable, serve, ball_toward;
  logic [9:0] ball_y;
  logic [9:0] paddle_y;
  logic       moving;
  logic [1:0] ai_state;

  int checks   = 0;
  int failures = 0;

  // Model state: paddle top, state code, prescaler phase, reaction steps, moved flag.
  int m_y, m_st, m_cnt, m_react, m_mov;

  ai_paddle_ctrl #(.TICK_DIV(TD)) dut (
    .clock_in    (clock_in),
    .reset       (reset),
    .enable      (enable),
    .serve       (serve),
    .ball_y      (ball_y),
    .ball_toward (ball_toward),
    .paddle_y    (paddle_y),
    .moving      (moving),
    .ai_state    (ai_state)
  );

  always #5 clock_in = ~clock_in;

  task automatic model_next();
    int step, d, err;
    step = (enable && m_cnt == TD - 1) ? 1 : 0;
    d = 0;
    if (reset) begin
      m_y = CEN; m_st = 0; m_cnt = 0; m_react = 0; m_mov = 0;
    end else if (serve) begin
      m_y = CEN; m_cnt = 0; m_react = 0; m_mov = 0;
      m_st = ball_toward ? ENTRY : 3;
    end else if (!enable) begin
      m_st = 0; m_cnt = 0; m_react = 0; m_mov = 0;
    end else begin
      m_cnt = (m_cnt + 1) % TD;
      case (m_st)
        0: m_st = ball_toward ? ENTRY : 3;
`ifdef AI_REACT_DELAY_EN
        1: begin
          if (!ball_toward) begin
            m_st = 3; m_react = 0;
          end else if (step == 1) begin
            m_react = m_react + 1;
            if (m_react == RS) begin m_react = 0; m_st = 2; end
          end
        end
`endif
        2: begin
          if (!ball_toward) m_st = 3;
          else if (step == 1) begin
            err = int'(ball_y) - (m_y + HALF);
            d = (err > DB) ? 1 : ((err < -DB) ? -1 : 0);
          end
        end
        3: begin
          if (ball_toward) m_st = ENTRY;
          else if (step == 1) d = (m_y < CEN) ? 1 : ((m_y > CEN) ? -1 : 0);
        end
        default: m_st = 0;
      endcase
      m_mov = 0;
      if (d != 0 && m_y + d >= 0 && m_y + d <= YMAX) begin
        m_y = m_y + d;
        m_mov = 1;
      end
    end
  endtask

  task automatic tick();
    model_next();
    @(posedge clock_in);
    #1;
  endtask

  task automatic test_reset();
    logic [12:0] exp;
    reset = 1; enable = 0; serve = 0; ball_toward = 0; ball_y = 10'd0;
    tick(); tick();
    reset = 0;
    checks++;
    if (paddle_y !== 10'd200 || ai_state !== 2'd0 || moving !== 1'b0) begin
      failures++;
      $display("FAIL reset_values got y=%0d st=%0d mov=%0d want y=200 st=0 mov=0", paddle_y, ai_state, moving);
    end
    for (int i = 0; i < 20; i++) begin
      ball_y = 10'($urandom_range(0, 479)); ball_toward = 1'($urandom);
      tick();
      exp = {10'd200, 1'b0, 2'd0};
      checks++;
      if ({paddle_y, moving, ai_state} !== exp) begin
        failures++;
        $display("FAIL reset_hold cyc=%0d got y=%0d mov=%0d st=%0d want y=200 mov=0 st=0", i, paddle_y, moving, ai_state);
      end
    end
  endtask

  task automatic test_react();
    logic [12:0] exp;
    enable = 1; ball_toward = 1; ball_y = 10'd400;
    for (int i = 1; i <= 700; i++) begin
      tick();
      exp = {10'(m_y), 1'(m_mov), 2'(m_st)};
      checks++;
      if ({paddle_y, moving, ai_state} !== exp) begin
        failures++;
        $display("FAIL react_model cyc=%0d got y=%0d mov=%0d st=%0d want y=%0d mov=%0d st=%0d",
                 i, paddle_y, moving, ai_state, m_y, m_mov, m_st);
      end
`ifdef AI_REACT_DELAY_EN
      if (i == 31 || i == 32) begin
        checks++;
        if (ai_state !== ((i == 31) ? 2'd1 : 2'd2)) begin
          failures++;
          $display("FAIL react_delay cyc=%0d got st=%0d want st=%0d", i, ai_state, (i == 31) ? 1 : 2);
        end
      end
      if (i == 36) begin
`else
      if (i == 1) begin
        checks++;
        if (ai_state !== 2'd2) begin
          failures++;
          $display("FAIL react_direct cyc=%0d got st=%0d want st=2", i, ai_state);
        end
      end
      if (i == 4) begin
`endif
        checks++;
        if (paddle_y !== 10'd201 || moving !== 1'b1) begin
          failures++;
          $display("FAIL first_move cyc=%0d got y=%0d mov=%0d want y=201 mov=1", i, paddle_y, moving);
        end
      end
    end
    checks++;
    if (paddle_y !== 10'd356 || ai_state !== 2'd2) begin
      failures++;
      $display("FAIL track_settle got y=%0d st=%0d want y=356 st=2", paddle_y, ai_state);
    end
  endtask

  task automatic test_deadband();
    logic [12:0] exp;
    serve = 1; ball_toward = 1; ball_y = 10'd243;
    tick();
    serve = 0;
    for (int i = 0; i < 44; i++) begin
      tick();
      exp = {10'(m_y), 1'(m_mov), 2'(m_st)};
      checks++;
      if ({paddle_y, moving, ai_state} !== exp || paddle_y !== 10'd200 || moving !== 1'b0) begin
        failures++;
        $display("FAIL deadband_hold cyc=%0d got y=%0d mov=%0d st=%0d want y=200 mov=0 st=%0d",
                 i, paddle_y, moving, ai_state, m_st);
      end
    end
    ball_y = 10'd245;
    for (int i = 0; i < 12; i++) tick();
    checks++;
    if (paddle_y !== 10'd201) begin
      failures++;
      $display("FAIL deadband_move got y=%0d want y=201", paddle_y);
    end
  endtask

  task automatic test_clamp();
    logic [12:0] exp;
    ball_y = 10'd0;
    for (int i = 0; i < 900; i++) begin
      tick();
      exp = {10'(m_y), 1'(m_mov), 2'(m_st)};
      checks++;
      if ({paddle_y, moving, ai_state} !== exp || (i >= 880 && (paddle_y !== 10'd0 || moving !== 1'b0))) begin
        failures++;
        $display("FAIL clamp_low cyc=%0d got y=%0d mov=%0d st=%0d want y=%0d mov=%0d st=%0d",
                 i, paddle_y, moving, ai_state, m_y, m_mov, m_st);
      end
    end
    ball_y = 10'd479;
    for (int i = 0; i < 1700; i++) begin
      tick();
      exp = {10'(m_y), 1'(m_mov), 2'(m_st)};
      checks++;
      if ({paddle_y, moving, ai_state} !== exp || (i >= 1680 && (paddle_y !== 10'd400 || moving !== 1'b0))) begin
        failures++;
        $display("FAIL clamp_high cyc=%0d got y=%0d mov=%0d st=%0d want y=%0d mov=%0d st=%0d",
                 i, paddle_y, moving, ai_state, m_y, m_mov, m_st);
      end
    end
  endtask

  task automatic test_recenter();
    ball_y = 10'd336;
    for (int i = 0; i < 420; i++) tick();
    checks++;
    if (paddle_y !== 10'd300) begin
      failures++;
      $display("FAIL recenter_setup got y=%0d want y=300", paddle_y);
    end
    ball_toward = 0;
    tick();
    checks++;
    if (ai_state !== 2'd3) begin
      failures++;
      $display("FAIL recenter_enter got st=%0d want st=3", ai_state);
    end
    for (int i = 0; i < 420; i++) begin
      tick();
      checks++;
      if (paddle_y !== 10'(m_y) || moving !== 1'(m_mov)) begin
        failures++;
        $display("FAIL recenter_walk cyc=%0d got y=%0d mov=%0d want y=%0d mov=%0d", i, paddle_y, moving, m_y, m_mov);
      end
    end
    checks++;
    if (paddle_y !== 10'd200 || ai_state !== 2'd3) begin
      failures++;
      $display("FAIL recenter_hold got y=%0d st=%0d want y=200 st=3", paddle_y, ai_state);
    end
    ball_toward = 1;
    tick();
    checks++;
    if (ai_state !== 2'(ENTRY)) begin
      failures++;
      $display("FAIL recenter_exit got st=%0d want st=%0d", ai_state, ENTRY);
    end
  endtask

  task automatic test_simultaneous();
    serve = 1; ball_toward = 1; ball_y = 10'd394; enable = 1;
    tick();
    serve = 0;
    for (int i = 0; i < 700; i++) tick();
    checks++;
    if (paddle_y !== 10'd350) begin
      failures++;
      $display("FAIL simul_setup got y=%0d want y=350", paddle_y);
    end
    ball_y = 10'd0;
    for (int i = 0; i < TD && m_cnt != TD - 1; i++) tick();
    serve = 1;
    tick();
    serve = 0;
    checks++;
    if (paddle_y !== 10'd200 || moving !== 1'b0 || ai_state !== 2'(ENTRY)) begin
      failures++;
      $display("FAIL serve_on_step got y=%0d mov=%0d st=%0d want y=200 mov=0 st=%0d", paddle_y, moving, ai_state, ENTRY);
    end
    for (int i = 0; i < 10; i++) tick();
    reset = 1; serve = 1;
    tick();
    reset = 0; serve = 0;
    checks++;
    if (paddle_y !== 10'd200 || moving !== 1'b0 || ai_state !== 2'd0) begin
      failures++;
      $display("FAIL reset_with_serve got y=%0d mov=%0d st=%0d want y=200 mov=0 st=0", paddle_y, moving, ai_state);
    end
  endtask

  task automatic test_random();
    logic [12:0] exp;
    for (int i = 0; i < 4000; i++) begin
      reset = ($urandom_range(0, 299) == 0);
      serve = ($urandom_range(0, 79) == 0);
      if ($urandom_range(0, 63) == 0) enable = ~enable;
      if ($urandom_range(0, 39) == 0) ball_toward = ~ball_toward;
      if ($urandom_range(0, 7) == 0) ball_y = 10'($urandom_range(0, 479));
      tick();
      exp = {10'(m_y), 1'(m_mov), 2'(m_st)};
      checks++;
      if ({paddle_y, moving, ai_state} !== exp) begin
        failures++;
        $display("FAIL random cyc=%0d got y=%0d mov=%0d st=%0d want y=%0d mov=%0d st=%0d",
                 i, paddle_y, moving, ai_state, m_y, m_mov, m_st);
      end
    end
    reset = 0; serve = 0;
  endtask

  initial begin
    test_reset();
    test_react();
    test_deadband();
    test_clamp();
    test_recenter();
    test_simultaneous();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
